// File: rtl/trap_ctrl_if.sv
// Pipeline-side bundle for the M-mode trap controller: retirement stream,
// exception/mret indications, interrupt lines, CSR access and redirect output.
interface trap_ctrl_if #(
  parameter int XLEN = 64
);
  logic            retire_valid;
  logic [XLEN-1:0] retire_npc;
  logic            exception;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_cause;
  logic [XLEN-1:0] exc_tval;
  logic            mret;
  logic            ext_irq;
  logic            sw_irq;
  logic            timer_irq;
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic [11:0]     csr_raddr;
  logic [XLEN-1:0] csr_rdata;
  logic [1:0]      priv;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output retire_valid, retire_npc, exception, exc_pc, exc_cause, exc_tval,
           mret, ext_irq, sw_irq, timer_irq, csr_we, csr_waddr, csr_wdata,
           csr_raddr,
    input  csr_rdata, priv, redirect_valid, redirect_pc
  );

  modport slave (
    input  retire_valid, retire_npc, exception, exc_pc, exc_cause, exc_tval,
           mret, ext_irq, sw_irq, timer_irq, csr_we, csr_waddr, csr_wdata,
           csr_raddr,
    output csr_rdata, priv, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap/interrupt controller at writeback. Owns the M-mode trap
// CSRs, selects one event per cycle (exception > mret > interrupt) and emits a
// registered one-cycle redirect pulse used to flush the pipeline.
module trap_ctrl #(
  parameter int         XLEN       = 64,
  parameter logic [1:0] RESET_PRIV = 2'b11
) (
  input  logic      clk,
  input  logic      reset,
  trap_ctrl_if.slave bus
);
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;
  localparam logic [11:0] A_MIP     = 12'h344;

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      priv_q, priv_d;
  logic            st_mie_q, st_mie_d;
  logic            st_mpie_q, st_mpie_d;
  logic [1:0]      st_mpp_q, st_mpp_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic            rdr_vld_q, rdr_vld_d;
  logic [XLEN-1:0] rdr_pc_q, rdr_pc_d;

  logic [XLEN-1:0] mip, mstatus, pend, tvec_base, irq_tgt;
  logic [3:0]      irq_code;
  logic            irq_ok;

  // mip mirrors the live interrupt lines; mstatus exposes only MIE/MPIE/MPP
  always_comb begin
    mip          = '0;
    mip[11]      = bus.ext_irq;
    mip[7]       = bus.timer_irq;
    mip[3]       = bus.sw_irq;
    mstatus      = '0;
    mstatus[3]   = st_mie_q;
    mstatus[7]   = st_mpie_q;
    mstatus[12:11] = st_mpp_q;
  end

  // Interrupt eligibility, source priority MEI > MSI > MTI, and vectored target
  always_comb begin
    pend      = mip & mie_q;
    irq_ok    = (|pend) && ((priv_q != 2'b11) || st_mie_q);
    irq_code  = pend[11] ? 4'd11 : (pend[3] ? 4'd3 : 4'd7);
    tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
    irq_tgt   = (mtvec_q[1:0] == 2'b01) ? tvec_base + XLEN'({irq_code, 2'b00})
                                        : tvec_base;
  end

  // Combinational CSR read; same-cycle writes are not visible here
  always_comb begin
    bus.csr_rdata = '0;
    case (bus.csr_raddr)
      A_MSTATUS: bus.csr_rdata = mstatus;
      A_MIE:     bus.csr_rdata = mie_q;
      A_MTVEC:   bus.csr_rdata = mtvec_q;
      A_MEPC:    bus.csr_rdata = mepc_q;
      A_MCAUSE:  bus.csr_rdata = mcause_q;
      A_MTVAL:   bus.csr_rdata = mtval_q;
      A_MIP:     bus.csr_rdata = mip;
      default:   bus.csr_rdata = '0;
    endcase
  end

  // Event selection and CSR next-state; trap updates shadow a same-cycle write
  always_comb begin
    state_d   = IDLE;
    priv_d    = priv_q;
    st_mie_d  = st_mie_q;
    st_mpie_d = st_mpie_q;
    st_mpp_d  = st_mpp_q;
    mie_d     = mie_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    mtval_d   = mtval_q;
    rdr_vld_d = 1'b0;
    rdr_pc_d  = rdr_pc_q;
    case (state_q)
      IDLE: begin
        if (bus.retire_valid && bus.exception) begin
          mepc_d    = bus.exc_pc;
          mcause_d  = bus.exc_cause;
          mtval_d   = bus.exc_tval;
          st_mpie_d = st_mie_q;
          st_mie_d  = 1'b0;
          st_mpp_d  = priv_q;
          priv_d    = 2'b11;
          rdr_vld_d = 1'b1;
          rdr_pc_d  = tvec_base;
          state_d   = REDIRECT;
        end else if (bus.retire_valid && bus.mret) begin
          st_mie_d  = st_mpie_q;
          st_mpie_d = 1'b1;
          priv_d    = st_mpp_q;
          st_mpp_d  = 2'b00;
          rdr_vld_d = 1'b1;
          rdr_pc_d  = mepc_q;
          state_d   = REDIRECT;
        end else if (bus.retire_valid && irq_ok) begin
          mepc_d    = bus.retire_npc;
          mcause_d  = {1'b1, (XLEN-1)'(irq_code)};
          mtval_d   = '0;
          st_mpie_d = st_mie_q;
          st_mie_d  = 1'b0;
          st_mpp_d  = priv_q;
          priv_d    = 2'b11;
          rdr_vld_d = 1'b1;
          rdr_pc_d  = irq_tgt;
          state_d   = REDIRECT;
        end else if (bus.csr_we) begin
          case (bus.csr_waddr)
            A_MSTATUS: begin
              st_mie_d  = bus.csr_wdata[3];
              st_mpie_d = bus.csr_wdata[7];
              st_mpp_d  = bus.csr_wdata[12:11];
            end
            A_MIE:    mie_d    = bus.csr_wdata;
            A_MTVEC:  mtvec_d  = bus.csr_wdata;
            A_MEPC:   mepc_d   = {bus.csr_wdata[XLEN-1:2], 2'b00};
            A_MCAUSE: mcause_d = bus.csr_wdata;
            A_MTVAL:  mtval_d  = bus.csr_wdata;
            default: ;
          endcase
        end
      end
      // Flush cycle: inputs belong to squashed instructions
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State register; reset overrides everything including an in-flight redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      priv_q    <= RESET_PRIV;
      st_mie_q  <= 1'b0;
      st_mpie_q <= 1'b0;
      st_mpp_q  <= 2'b00;
      mie_q     <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
      mtval_q   <= '0;
      rdr_vld_q <= 1'b0;
      rdr_pc_q  <= '0;
    end else begin
      state_q   <= state_d;
      priv_q    <= priv_d;
      st_mie_q  <= st_mie_d;
      st_mpie_q <= st_mpie_d;
      st_mpp_q  <= st_mpp_d;
      mie_q     <= mie_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
      mtval_q   <= mtval_d;
      rdr_vld_q <= rdr_vld_d;
      rdr_pc_q  <= rdr_pc_d;
    end
  end

  assign bus.priv           = priv_q;
  assign bus.redirect_valid = rdr_vld_q;
  assign bus.redirect_pc    = rdr_pc_q;
endmodule
